// File: rtl/ysyx_22040759_mem_arbiter_pkg.sv
// ysyx_22040759_mem_arbiter_pkg
// Shared definitions for the IFU/LSU memory arbiter: bus widths, FSM state
// encodings, owner encodings, the latched request record and the helper that
// picks the 32-bit instruction half out of a 64-bit memory word.
package ysyx_22040759_mem_arbiter_pkg;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_REQ  = 2'd1;
  localparam logic [1:0] ARB_WAIT = 2'd2;
  localparam logic [1:0] ARB_RESP = 2'd3;

  localparam logic OWNER_IFU = 1'b0;
  localparam logic OWNER_LSU = 1'b1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              wen;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wmask;
  } mem_req_t;

  // Instructions are 4-byte aligned inside an 8-byte word; addr[2] picks the half.
  function automatic logic [31:0] select_inst(input logic [DATA_W-1:0] rdata,
                                              input logic              upper);
    return upper ? rdata[63:32] : rdata[31:0];
  endfunction

endpackage

// File: rtl/ysyx_22040759_mem_arbiter_if.sv
// ysyx_22040759_mem_arbiter_if
// Bundles every handshake/bus signal around the arbiter.
//   ifu_*  : instruction fetch request/response and flush
//   lsu_*  : load/store request/response
//   mem_*  : single downstream memory port
//   err    : sticky protocol error flag
// Modports:
//   slave  : the arbiter's view (serves IFU/LSU, drives the memory port)
//   master : the environment's view (requesters and memory model)
interface ysyx_22040759_mem_arbiter_if;
  import ysyx_22040759_mem_arbiter_pkg::*;

  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [ADDR_W-1:0] ifu_req_addr;
  logic              ifu_flush;
  logic              ifu_resp_valid;
  logic [31:0]       ifu_resp_inst;

  logic              lsu_req_valid;
  logic              lsu_req_ready;
  logic [ADDR_W-1:0] lsu_req_addr;
  logic              lsu_req_wen;
  logic [DATA_W-1:0] lsu_req_wdata;
  logic [STRB_W-1:0] lsu_req_wmask;
  logic              lsu_resp_valid;
  logic [DATA_W-1:0] lsu_resp_rdata;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_wen;
  logic [DATA_W-1:0] mem_req_wdata;
  logic [STRB_W-1:0] mem_req_wmask;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_rdata;

  logic              err;

  modport slave (
    input  ifu_req_valid, ifu_req_addr, ifu_flush,
    output ifu_req_ready, ifu_resp_valid, ifu_resp_inst,
    input  lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
    output lsu_req_ready, lsu_resp_valid, lsu_resp_rdata,
    output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata,
    output err
  );

  modport master (
    output ifu_req_valid, ifu_req_addr, ifu_flush,
    input  ifu_req_ready, ifu_resp_valid, ifu_resp_inst,
    output lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
    input  lsu_req_ready, lsu_resp_valid, lsu_resp_rdata,
    input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata,
    input  err
  );

endinterface

// File: rtl/ysyx_22040759_mem_arbiter.sv
// ysyx_22040759_mem_arbiter
// Shares one memory port between IFU and LSU with round-robin grant and a
// single outstanding transaction.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous, active-low reset
//   bus : ysyx_22040759_mem_arbiter_if.slave (IFU, LSU, memory, err)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ARB_IDLE | readies offered to the round-robin winner, request latched
// ARB_REQ  | mem_req_valid held with latched fields until mem_req_ready
// ARB_WAIT | waiting for mem_resp_valid, rdata captured on arrival
// ARB_RESP | one-cycle resp_valid pulse to the owner (unless IFU dropped)
module ysyx_22040759_mem_arbiter
  import ysyx_22040759_mem_arbiter_pkg::*;
(
  input logic                          clk,
  input logic                          rst,
  ysyx_22040759_mem_arbiter_if.slave   bus
);

  logic [1:0]        state;
  logic              owner;
  logic              last_grant;
  logic              drop;
  logic              err_q;
  mem_req_t          req_q;
  logic [DATA_W-1:0] rdata_q;

  logic grant_ifu;
  logic grant_lsu;

  // On a tie, the requester that did not win last time gets the port.
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (state == ARB_IDLE) begin
      if (bus.ifu_req_valid && bus.lsu_req_valid) begin
        if (last_grant == OWNER_LSU) grant_ifu = 1'b1;
        else                         grant_lsu = 1'b1;
      end else if (bus.ifu_req_valid) begin
        grant_ifu = 1'b1;
      end else if (bus.lsu_req_valid) begin
        grant_lsu = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ARB_IDLE;
      owner      <= OWNER_IFU;
      last_grant <= OWNER_LSU;
      drop       <= 1'b0;
      err_q      <= 1'b0;
      req_q      <= '0;
      rdata_q    <= '0;
    end else begin
      if (bus.mem_resp_valid && (state != ARB_WAIT)) err_q <= 1'b1;

      if (bus.ifu_flush && (owner == OWNER_IFU) && (state != ARB_IDLE)) drop <= 1'b1;

      case (state)
        ARB_IDLE: begin
          if (grant_ifu) begin
            req_q      <= '{addr: bus.ifu_req_addr, wen: 1'b0, wdata: '0, wmask: '1};
            owner      <= OWNER_IFU;
            last_grant <= OWNER_IFU;
            state      <= ARB_REQ;
          end else if (grant_lsu) begin
            req_q      <= '{addr: bus.lsu_req_addr, wen: bus.lsu_req_wen,
                            wdata: bus.lsu_req_wdata, wmask: bus.lsu_req_wmask};
            owner      <= OWNER_LSU;
            last_grant <= OWNER_LSU;
            state      <= ARB_REQ;
          end
        end
        ARB_REQ: begin
          if (bus.mem_req_ready) state <= ARB_WAIT;
        end
        ARB_WAIT: begin
          if (bus.mem_resp_valid) begin
            rdata_q <= bus.mem_resp_rdata;
            state   <= ARB_RESP;
          end
        end
        ARB_RESP: begin
          // Clearing here overrides any flush seen in this same cycle.
          drop  <= 1'b0;
          state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign bus.ifu_req_ready  = grant_ifu;
  assign bus.lsu_req_ready  = grant_lsu;

  assign bus.mem_req_valid  = (state == ARB_REQ);
  assign bus.mem_req_addr   = req_q.addr;
  assign bus.mem_req_wen    = req_q.wen;
  assign bus.mem_req_wdata  = req_q.wdata;
  assign bus.mem_req_wmask  = req_q.wmask;

  // A flush arriving in RESP itself also kills the pulse it would meet.
  assign bus.ifu_resp_valid = (state == ARB_RESP) && (owner == OWNER_IFU) &&
                              !drop && !bus.ifu_flush;
  assign bus.ifu_resp_inst  = select_inst(rdata_q, req_q.addr[2]);

  assign bus.lsu_resp_valid = (state == ARB_RESP) && (owner == OWNER_LSU);
  assign bus.lsu_resp_rdata = rdata_q;

  assign bus.err            = err_q;

endmodule

// File: tb/tb_ysyx_22040759_mem_arbiter.sv
module tb_ysyx_22040759_mem_arbiter;
  import ysyx_22040759_mem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  ysyx_22040759_mem_arbiter_if bus ();

  ysyx_22040759_mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.ifu_req_valid  = 1'b0;
    bus.ifu_req_addr   = '0;
    bus.ifu_flush      = 1'b0;
    bus.lsu_req_valid  = 1'b0;
    bus.lsu_req_addr   = '0;
    bus.lsu_req_wen    = 1'b0;
    bus.lsu_req_wdata  = '0;
    bus.lsu_req_wmask  = '0;
    bus.mem_req_ready  = 1'b1;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_rdata = '0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1'b0;
    #2;
    checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_req_valid: got %b expected 0", bus.mem_req_valid); end
    checks++; if (bus.ifu_resp_valid !== 1'b0) begin errors++; $display("FAIL reset_ifu_resp_valid: got %b expected 0", bus.ifu_resp_valid); end
    checks++; if (bus.lsu_resp_valid !== 1'b0) begin errors++; $display("FAIL reset_lsu_resp_valid: got %b expected 0", bus.lsu_resp_valid); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.err); end
    checks++; if (bus.mem_req_addr !== 64'h0) begin errors++; $display("FAIL reset_mem_req_addr: got %h expected 0", bus.mem_req_addr); end
    checks++; if (bus.mem_req_wmask !== 8'h00) begin errors++; $display("FAIL reset_mem_req_wmask: got %h expected 00", bus.mem_req_wmask); end
    checks++; if (bus.ifu_resp_inst !== 32'h0) begin errors++; $display("FAIL reset_ifu_resp_inst: got %h expected 0", bus.ifu_resp_inst); end
    tick();
    rst = 1'b1;
    tick();
    checks++; if ({bus.ifu_req_ready, bus.lsu_req_ready} !== 2'b00) begin errors++; $display("FAIL idle_readies: got %b expected 00", {bus.ifu_req_ready, bus.lsu_req_ready}); end
  endtask

  // Full IFU read with a 1-cycle memory; starts and ends in IDLE.
  task automatic ifu_txn(input logic [63:0] addr, input logic [63:0] rdata,
                         input logic [31:0] exp_inst);
    bus.ifu_req_valid = 1'b1;
    bus.ifu_req_addr  = addr;
    #1;
    checks++; if (bus.ifu_req_ready !== 1'b1) begin errors++; $display("FAIL ifu_accept_c0: got %b expected 1", bus.ifu_req_ready); end
    tick();
    bus.ifu_req_valid = 1'b0;
    #1;
    checks++; if (bus.mem_req_valid !== 1'b1) begin errors++; $display("FAIL ifu_mem_valid_c1: got %b expected 1", bus.mem_req_valid); end
    checks++; if (bus.mem_req_addr !== addr) begin errors++; $display("FAIL ifu_mem_addr: got %h expected %h", bus.mem_req_addr, addr); end
    checks++; if ({bus.mem_req_wen, bus.mem_req_wmask} !== 9'h0FF) begin errors++; $display("FAIL ifu_mem_wen_wmask: got %h expected 0ff", {bus.mem_req_wen, bus.mem_req_wmask}); end
    tick();
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = rdata;
    #1;
    checks++; if (bus.ifu_resp_valid !== 1'b0) begin errors++; $display("FAIL ifu_resp_early_c2: got %b expected 0", bus.ifu_resp_valid); end
    tick();
    bus.mem_resp_valid = 1'b0;
    #1;
    checks++; if (bus.ifu_resp_valid !== 1'b1) begin errors++; $display("FAIL ifu_resp_valid_c3: got %b expected 1", bus.ifu_resp_valid); end
    checks++; if (bus.ifu_resp_inst !== exp_inst) begin errors++; $display("FAIL ifu_resp_inst: got %h expected %h", bus.ifu_resp_inst, exp_inst); end
    tick();
    #1;
    checks++; if (bus.ifu_resp_valid !== 1'b0) begin errors++; $display("FAIL ifu_resp_pulse_c4: got %b expected 0", bus.ifu_resp_valid); end
  endtask

  task automatic test_round_robin;
    logic exp_ifu;
    logic [63:0] exp_addr;
    do_reset();
    bus.ifu_req_valid = 1'b1;
    bus.ifu_req_addr  = 64'h8000_0000;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_req_addr  = 64'h8000_0200;
    bus.lsu_req_wen   = 1'b0;
    bus.lsu_req_wmask = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      exp_ifu  = (i % 2 == 0);
      exp_addr = exp_ifu ? 64'h8000_0000 : 64'h8000_0200;
      #1;
      checks++; if ({bus.ifu_req_ready, bus.lsu_req_ready} !== {exp_ifu, ~exp_ifu}) begin errors++; $display("FAIL rr_grant_%0d: got %b expected %b", i, {bus.ifu_req_ready, bus.lsu_req_ready}, {exp_ifu, ~exp_ifu}); end
      tick();
      #1;
      checks++; if (bus.mem_req_addr !== exp_addr) begin errors++; $display("FAIL rr_mem_addr_%0d: got %h expected %h", i, bus.mem_req_addr, exp_addr); end
      checks++; if ({bus.ifu_req_ready, bus.lsu_req_ready} !== 2'b00) begin errors++; $display("FAIL rr_ready_busy_%0d: got %b expected 00", i, {bus.ifu_req_ready, bus.lsu_req_ready}); end
      tick();
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_rdata = 64'h0123_4567_89AB_CDEF;
      tick();
      bus.mem_resp_valid = 1'b0;
      #1;
      checks++; if ({bus.ifu_resp_valid, bus.lsu_resp_valid} !== {exp_ifu, ~exp_ifu}) begin errors++; $display("FAIL rr_resp_owner_%0d: got %b expected %b", i, {bus.ifu_resp_valid, bus.lsu_resp_valid}, {exp_ifu, ~exp_ifu}); end
      if (!exp_ifu) begin
        checks++; if (bus.lsu_resp_rdata !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL rr_lsu_rdata_%0d: got %h expected 0123456789abcdef", i, bus.lsu_resp_rdata); end
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_lsu_write_stall;
    bus.mem_req_ready = 1'b0;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_req_addr  = 64'h8000_0100;
    bus.lsu_req_wen   = 1'b1;
    bus.lsu_req_wdata = 64'h0000_0000_DEAD_BEEF;
    bus.lsu_req_wmask = 8'h0F;
    #1;
    checks++; if ({bus.ifu_req_ready, bus.lsu_req_ready} !== 2'b01) begin errors++; $display("FAIL wr_accept: got %b expected 01", {bus.ifu_req_ready, bus.lsu_req_ready}); end
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 1) begin
        bus.lsu_req_valid = 1'b0;
        bus.lsu_req_addr  = 64'h0;
        bus.lsu_req_wdata = 64'h0;
        bus.lsu_req_wmask = 8'h00;
      end
      if (c == 4) bus.mem_req_ready = 1'b1;
      #1;
      checks++; if (bus.mem_req_valid !== 1'b1) begin errors++; $display("FAIL wr_valid_c%0d: got %b expected 1", c, bus.mem_req_valid); end
      checks++; if (bus.mem_req_addr !== 64'h8000_0100) begin errors++; $display("FAIL wr_addr_c%0d: got %h expected 80000100", c, bus.mem_req_addr); end
      checks++; if (bus.mem_req_wen !== 1'b1) begin errors++; $display("FAIL wr_wen_c%0d: got %b expected 1", c, bus.mem_req_wen); end
      checks++; if (bus.mem_req_wdata !== 64'h0000_0000_DEAD_BEEF) begin errors++; $display("FAIL wr_wdata_c%0d: got %h expected deadbeef", c, bus.mem_req_wdata); end
      checks++; if (bus.mem_req_wmask !== 8'h0F) begin errors++; $display("FAIL wr_wmask_c%0d: got %h expected 0f", c, bus.mem_req_wmask); end
    end
    tick();
    #1;
    checks++; if ({bus.mem_req_valid, bus.lsu_resp_valid} !== 2'b00) begin errors++; $display("FAIL wr_wait: got %b expected 00", {bus.mem_req_valid, bus.lsu_resp_valid}); end
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 64'h0000_0000_0000_CAFE;
    tick();
    bus.mem_resp_valid = 1'b0;
    #1;
    checks++; if ({bus.ifu_resp_valid, bus.lsu_resp_valid} !== 2'b01) begin errors++; $display("FAIL wr_resp: got %b expected 01", {bus.ifu_resp_valid, bus.lsu_resp_valid}); end
    tick();
    #1;
    checks++; if (bus.lsu_resp_valid !== 1'b0) begin errors++; $display("FAIL wr_resp_pulse: got %b expected 0", bus.lsu_resp_valid); end
    idle_inputs();
  endtask

  task automatic test_flush(input bit same_cycle);
    bus.ifu_req_valid = 1'b1;
    bus.ifu_req_addr  = 64'h8000_0008;
    #1;
    tick();
    bus.ifu_req_valid = 1'b0;
    tick();
    bus.ifu_flush = 1'b1;
    if (same_cycle) begin
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_rdata = 64'h9999_AAAA_BBBB_CCCC;
    end else begin
      tick();
      bus.ifu_flush      = 1'b0;
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_rdata = 64'h9999_AAAA_BBBB_CCCC;
    end
    tick();
    bus.ifu_flush      = 1'b0;
    bus.mem_resp_valid = 1'b0;
    #1;
    checks++; if ({bus.ifu_resp_valid, bus.lsu_resp_valid} !== 2'b00) begin errors++; $display("FAIL flush_drop_%0d: got %b expected 00", same_cycle, {bus.ifu_resp_valid, bus.lsu_resp_valid}); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL flush_err_%0d: got %b expected 0", same_cycle, bus.err); end
    tick();
    ifu_txn(64'h8000_0000, 64'h5555_6666_7777_8888, 32'h7777_8888);
  endtask

  task automatic test_spurious;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    tick();
    bus.mem_resp_valid = 1'b0;
    #1;
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL spur_err: got %b expected 1", bus.err); end
    checks++; if ({bus.ifu_resp_valid, bus.lsu_resp_valid, bus.mem_req_valid} !== 3'b000) begin errors++; $display("FAIL spur_pulses: got %b expected 000", {bus.ifu_resp_valid, bus.lsu_resp_valid, bus.mem_req_valid}); end
    tick();
    tick();
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL spur_err_sticky: got %b expected 1", bus.err); end
  endtask

  task automatic test_reset_mid;
    bus.ifu_req_valid = 1'b1;
    bus.ifu_req_addr  = 64'h8000_0004;
    #1;
    tick();
    bus.ifu_req_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL rstmid_mem_valid: got %b expected 0", bus.mem_req_valid); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL rstmid_err: got %b expected 0", bus.err); end
    checks++; if (bus.mem_req_addr !== 64'h0) begin errors++; $display("FAIL rstmid_mem_addr: got %h expected 0", bus.mem_req_addr); end
    checks++; if (bus.mem_req_wmask !== 8'h00) begin errors++; $display("FAIL rstmid_wmask: got %h expected 00", bus.mem_req_wmask); end
    checks++; if (bus.lsu_resp_rdata !== 64'h0) begin errors++; $display("FAIL rstmid_rdata: got %h expected 0", bus.lsu_resp_rdata); end
    checks++; if ({bus.ifu_req_ready, bus.lsu_req_ready, bus.ifu_resp_valid, bus.lsu_resp_valid} !== 4'b0000) begin errors++; $display("FAIL rstmid_flags: got %b expected 0000", {bus.ifu_req_ready, bus.lsu_req_ready, bus.ifu_resp_valid, bus.lsu_resp_valid}); end
    tick();
    rst = 1'b1;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 64'h1234;
    tick();
    bus.mem_resp_valid = 1'b0;
    #1;
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL rstmid_late_resp_err: got %b expected 1", bus.err); end
    tick();
    ifu_txn(64'h8000_0004, 64'h1111_2222_3333_4444, 32'h1111_2222);
  endtask

  initial begin
    test_reset();
    ifu_txn(64'h8000_0004, 64'h1111_2222_3333_4444, 32'h1111_2222);
    ifu_txn(64'h8000_0000, 64'h1111_2222_3333_4444, 32'h3333_4444);
    test_round_robin();
    test_lsu_write_stall();
    test_flush(1'b0);
    test_flush(1'b1);
    test_spurious();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_22040759_mem_arbiter.md
# ysyx_22040759_mem_arbiter

Two-requester arbiter that shares the single physical memory port between instruction fetch (IFU) and load/store (LSU) in the ysyx_22040759 core. It replaces per-unit direct memory calls with one sequenced, one-outstanding-transaction port. It applies round-robin grant, latches the winning request and drives it downstream. It returns the response to the owner, selecting the 32-bit instruction half for IFU.

## Interface
- ADDR_W, 64, address width
- DATA_W, 64, memory data width (fixed 64; wmask is DATA_W/8)
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- ifu_req_valid / ifu_req_ready  in / out  1  IFU request handshake
- ifu_req_addr  in  ADDR_W  fetch address (4-byte aligned)
- ifu_flush  in  1  discard any in-flight IFU response
- ifu_resp_valid  out  1  one-cycle pulse, instruction available
- ifu_resp_inst  out  32  rdata[31:0] if latched addr[2]==0, else rdata[63:32]
- lsu_req_valid / lsu_req_ready  in / out  1  LSU request handshake
- lsu_req_addr  in  ADDR_W;  lsu_req_wen  in  1;  lsu_req_wdata  in  DATA_W;  lsu_req_wmask  in  8
- lsu_resp_valid  out  1  one-cycle pulse; lsu_resp_rdata  out  DATA_W (don't-care for writes)
- mem_req_valid / mem_req_ready  out / in  1  downstream request handshake
- mem_req_addr  out  ADDR_W;  mem_req_wen  out  1;  mem_req_wdata  out  DATA_W;  mem_req_wmask  out  8
- mem_resp_valid  in  1;  mem_resp_rdata  in  DATA_W  (one response per request, reads and writes)
- err  out  1  sticky: mem_resp_valid seen outside WAIT

## Operation
- States: IDLE, REQ, WAIT, RESP. Owner register: IFU or LSU. last_grant register.
- IDLE: if exactly one valid, grant it. If both valid, grant the one not equal to last_grant. Assert that requester's req_ready combinationally in this cycle and latch addr/wen/wdata/wmask. IFU latches are wen=0 and wmask=0xFF. Update owner and last_grant, then go to REQ. With no valid, stay in IDLE with both readies 0.
- Readies are 0 in every state except IDLE.
- REQ: mem_req_valid=1 with latched fields, held stable until mem_req_ready. On handshake go to WAIT.
- WAIT: on mem_resp_valid, register rdata and go to RESP.
- RESP: pulse the owner's resp_valid with the registered data, then go to IDLE. There is no upstream backpressure; requesters must accept.
- Flush: if ifu_flush is asserted while owner=IFU in REQ, WAIT or RESP, a drop flag is set. Flush does not cancel an issued or pending mem request; the transaction completes downstream. The drop flag suppresses ifu_resp_valid in RESP. The drop flag clears on return to IDLE. ifu_flush in IDLE, or with owner=LSU, has no effect.
- mem_resp_valid in IDLE, REQ or RESP: ignored for data and sets err.
- Write response to LSU: lsu_resp_valid pulses, and lsu_resp_rdata carries the registered mem_resp_rdata (meaningless).

## Timing
- Reset values: state=IDLE, owner=IFU, last_grant=LSU (so IFU wins the first tie), drop=0, err=0. All valid and ready outputs are 0, and data outputs are 0.
- Reset mid-transaction returns to IDLE immediately (asynchronous). The downstream request is abandoned. A memory response that arrives after reset deassertion sets err.
- Accept at cycle 0 (IDLE, req_ready=1). mem_req_valid at cycle 1. With mem_req_ready=1 and a 1-cycle memory, mem_resp_valid at cycle 2 and resp_valid at cycle 3. Back-to-back accept is possible at cycle 4.
- General latency: resp_valid occurs 1 cycle after mem_resp_valid. Every mem_req_ready stall cycle adds 1.
- Simultaneous flush and mem_resp_valid in WAIT: the response is dropped.

## Structure
- Shared package/define file (ysyx_22040759_define.v): state encodings ARB_IDLE/REQ/WAIT/RESP, OWNER_IFU/OWNER_LSU constants, and ADDR_W/DATA_W defaults.
- Single module. The round-robin choice is small enough to stay inline; no sub-module.

## Test plan
- IFU only, addr 0x8000_0004, mem returns 0x1111_2222_3333_4444 one cycle after handshake -> ifu_resp_inst=0x1111_2222 at cycle 3; addr 0x8000_0000 -> 0x3333_4444.
- Both valid from reset -> IFU is served first, then LSU. Both held valid -> grants alternate IFU/LSU/IFU, and no requester is starved.
- LSU write addr 0x8000_0100, wdata 0xDEAD_BEEF, wmask 0x0F, mem_req_ready held low 3 cycles -> mem fields stable throughout, handshake on the 4th, lsu_resp_valid 1 cycle after mem_resp_valid.
- IFU in WAIT, ifu_flush pulsed -> no ifu_resp_valid. The next request is accepted normally after RESP.
- Spurious mem_resp_valid in IDLE -> err=1 and stays 1; no resp_valid pulses.
- rst asserted during WAIT -> all outputs are zero immediately. After release, a new IFU request completes with the standard 3-cycle latency.
